// File: rtl/ctrl_fsm_param_pkg.sv
// Shared state type and width helper for the SMAC volume controller.
// No logic; imported by ctrl_fsm_param and smac_loop_cnt.
package ctrl_fsm_param_pkg;

  typedef enum logic [2:0] {
    IDLE_P,
    LOAD_P,
    RUN_P,
    QUANT_WAIT_P,
    WRITE_BACK_P,
    FINISH_P
  } ctrl_p_states;

  // Index width for a loop of n iterations; a single-iteration loop still gets one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/smac_loop_cnt.sv
// Four-level nested wrap counter; level 0 is innermost, each wrap carries into the next level.
// Latency: indices update on the clock edge after inc; clear has priority over inc.
// Backpressure: holds while inc is low.
module smac_loop_cnt
  import ctrl_fsm_param_pkg::*;
#(
  parameter int N0 = 9,
  parameter int N1 = 8,
  parameter int N2 = 8,
  parameter int N3 = 4,
  localparam int W0 = clog2_min1(N0),
  localparam int W1 = clog2_min1(N1),
  localparam int W2 = clog2_min1(N2),
  localparam int W3 = clog2_min1(N3)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          inc,
  output logic [W0-1:0] idx0,
  output logic [W1-1:0] idx1,
  output logic [W2-1:0] idx2,
  output logic [W3-1:0] idx3,
  output logic          last0,
  output logic          last1,
  output logic          last2,
  output logic          last3,
  output logic          all_last
);

  logic [W0-1:0] idx0_q, idx0_d;
  logic [W1-1:0] idx1_q, idx1_d;
  logic [W2-1:0] idx2_q, idx2_d;
  logic [W3-1:0] idx3_q, idx3_d;

  assign last0    = (idx0_q == W0'(N0 - 1));
  assign last1    = (idx1_q == W1'(N1 - 1));
  assign last2    = (idx2_q == W2'(N2 - 1));
  assign last3    = (idx3_q == W3'(N3 - 1));
  assign all_last = last0 && last1 && last2 && last3;

  assign idx0 = idx0_q;
  assign idx1 = idx1_q;
  assign idx2 = idx2_q;
  assign idx3 = idx3_q;

  always_comb begin
    idx0_d = idx0_q;
    idx1_d = idx1_q;
    idx2_d = idx2_q;
    idx3_d = idx3_q;
    if (clear) begin
      idx0_d = '0;
      idx1_d = '0;
      idx2_d = '0;
      idx3_d = '0;
    end else if (inc) begin
      idx0_d = last0 ? '0 : idx0_q + W0'(1);
      if (last0) begin
        idx1_d = last1 ? '0 : idx1_q + W1'(1);
        if (last1) begin
          idx2_d = last2 ? '0 : idx2_q + W2'(1);
          if (last2) begin
            idx3_d = last3 ? '0 : idx3_q + W3'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx0_q <= '0;
      idx1_q <= '0;
      idx2_q <= '0;
      idx3_q <= '0;
    end else begin
      idx0_q <= idx0_d;
      idx1_q <= idx1_d;
      idx2_q <= idx2_d;
      idx3_q <= idx3_d;
    end
  end

endmodule

// File: rtl/ctrl_fsm_param.sv
// Sequences one SMAC volume: N_FIL filters x ACT_BITS x WEI_BITS x KW steps; SMAC_SIGNED_ACT_EN enables MSB_a.
// Latency: step outputs are Mealy in the step cycle; valid_ac2/valid_ac3/cl_en_ac2 follow one cycle later.
// Backpressure: core_stall_n low freezes RUN unless draining the last filter of the last volume.
module ctrl_fsm_param
  import ctrl_fsm_param_pkg::*;
#(
  parameter int KW       = 9,
  parameter int ACT_BITS = 8,
  parameter int WEI_BITS = 8,
  parameter int N_FIL    = 4,
  localparam int EW = clog2_min1(KW),
  localparam int WW = clog2_min1(WEI_BITS),
  localparam int AW = clog2_min1(ACT_BITS),
  localparam int FW = clog2_min1(N_FIL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_stall_n,
  input  logic          last_vol,
  input  logic          done_quant,
  input  logic          relu_done,
  output logic          act_load,
  output logic          wei_load,
  output logic          step_en,
  output logic [EW-1:0] elem_idx,
  output logic [WW-1:0] wbit_idx,
  output logic [AW-1:0] abit_idx,
  output logic [FW-1:0] fil_idx,
  output logic          cl_en_ac1,
  output logic          w_and_s_ac1,
  output logic          MSB_w,
  output logic          MSB_a,
  output logic          valid_ac2,
  output logic          valid_ac3,
  output logic          cl_en_ac2,
  output logic          wb,
  output logic          act_wb,
  output logic          busy,
  output logic          done
);

  ctrl_p_states state_q, state_d;
  logic last_vol_q, last_vol_d;
  logic valid_ac2_q, valid_ac2_d;
  logic valid_ac3_q, valid_ac3_d;
  logic cnt_clear, cnt_inc, step;
  logic elem_last, wbit_last, abit_last, fil_last, vol_last;
  logic drain;

  smac_loop_cnt #(
    .N0(KW),
    .N1(WEI_BITS),
    .N2(ACT_BITS),
    .N3(N_FIL)
  ) u_loop_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .inc     (cnt_inc),
    .idx0    (elem_idx),
    .idx1    (wbit_idx),
    .idx2    (abit_idx),
    .idx3    (fil_idx),
    .last0   (elem_last),
    .last1   (wbit_last),
    .last2   (abit_last),
    .last3   (fil_last),
    .all_last(vol_last)
  );

  assign drain = last_vol_q && fil_last;

  // The final step of a filter leaves the inner indices at max; the WRITE_BACK
  // exit increment then wraps them to zero and carries into the filter index.
  always_comb begin
    state_d    = state_q;
    last_vol_d = last_vol_q;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    step       = 1'b0;
    act_load   = 1'b0;
    wb         = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE_P: begin
        cnt_clear = 1'b1;
        if (core_stall_n) state_d = LOAD_P;
      end
      LOAD_P: begin
        if (core_stall_n) begin
          act_load   = 1'b1;
          last_vol_d = last_vol;
          state_d    = RUN_P;
        end
      end
      RUN_P: begin
        if (core_stall_n || drain) begin
          step = 1'b1;
          if (elem_last && wbit_last && abit_last) state_d = QUANT_WAIT_P;
          else                                     cnt_inc = 1'b1;
        end
      end
      QUANT_WAIT_P: begin
        if (done_quant) state_d = WRITE_BACK_P;
      end
      WRITE_BACK_P: begin
        wb = 1'b1;
        if (relu_done) begin
          if (vol_last) begin
            state_d = FINISH_P;
          end else begin
            cnt_inc = 1'b1;
            state_d = RUN_P;
          end
        end
      end
      FINISH_P: begin
        done      = 1'b1;
        cnt_clear = 1'b1;
        state_d   = IDLE_P;
      end
      default: state_d = IDLE_P;
    endcase
  end

  assign step_en     = step;
  assign cl_en_ac1   = step && (elem_idx == '0);
  assign w_and_s_ac1 = step && (elem_idx != '0);
  assign wei_load    = step && (abit_idx == '0) && (wbit_idx == '0);
  assign MSB_w       = step && wbit_last;
`ifdef SMAC_SIGNED_ACT_EN
  assign MSB_a       = step && abit_last;
`else
  assign MSB_a       = 1'b0;
`endif

  assign valid_ac2_d = step && elem_last;
  assign valid_ac3_d = step && elem_last && wbit_last;
  assign valid_ac2   = valid_ac2_q;
  assign valid_ac3   = valid_ac3_q;
  assign cl_en_ac2   = valid_ac3_q;
  assign act_wb      = wb;
  assign busy        = (state_q != IDLE_P);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE_P;
      last_vol_q  <= 1'b0;
      valid_ac2_q <= 1'b0;
      valid_ac3_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_vol_q  <= last_vol_d;
      valid_ac2_q <= valid_ac2_d;
      valid_ac3_q <= valid_ac3_d;
    end
  end

endmodule

// File: tb/tb_ctrl_fsm_param.sv
// Self-checking bench for ctrl_fsm_param: vector table, directed corner sequences and
// randomized handshakes against a step-number based reference model.
module tb_ctrl_fsm_param;
  import ctrl_fsm_param_pkg::*;

  localparam int KW = 9, AB = 8, WB = 8, NF = 4;
  localparam int EW = clog2_min1(KW), WW = clog2_min1(WB), AW = clog2_min1(AB), FW = clog2_min1(NF);
  localparam int STEPS = KW * WB * AB;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_QW = 3, M_WB = 4, M_FIN = 5;
`ifdef SMAC_SIGNED_ACT_EN
  localparam int MSBA_PER_FIL = KW * WB;
`else
  localparam int MSBA_PER_FIL = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic core_stall_n = 1'b0, last_vol = 1'b0, done_quant = 1'b0, relu_done = 1'b0;
  logic act_load, wei_load, step_en, cl_en_ac1, w_and_s_ac1, MSB_w, MSB_a;
  logic valid_ac2, valid_ac3, cl_en_ac2, wb, act_wb, busy, done;
  logic [EW-1:0] elem_idx;
  logic [WW-1:0] wbit_idx;
  logic [AW-1:0] abit_idx;
  logic [FW-1:0] fil_idx;

  always #5 clk = ~clk;

  ctrl_fsm_param #(.KW(KW), .ACT_BITS(AB), .WEI_BITS(WB), .N_FIL(NF)) dut (
    .clk(clk), .rst_n(rst_n), .core_stall_n(core_stall_n), .last_vol(last_vol),
    .done_quant(done_quant), .relu_done(relu_done), .act_load(act_load), .wei_load(wei_load),
    .step_en(step_en), .elem_idx(elem_idx), .wbit_idx(wbit_idx), .abit_idx(abit_idx),
    .fil_idx(fil_idx), .cl_en_ac1(cl_en_ac1), .w_and_s_ac1(w_and_s_ac1), .MSB_w(MSB_w),
    .MSB_a(MSB_a), .valid_ac2(valid_ac2), .valid_ac3(valid_ac3), .cl_en_ac2(cl_en_ac2),
    .wb(wb), .act_wb(act_wb), .busy(busy), .done(done)
  );

  int n_checks = 0, n_fail = 0;
  int m_mode, m_s, m_fil;
  bit m_lv, m_v2, m_v3;
  int sn_step, sn_act, sn_busy, sn_elem, sn_cl, sn_ws, sn_wl, sn_fil, sn_done, sn_wb;
  int cnt_step, cnt_v2, cnt_v3, cnt_msbw, cnt_msba, cnt_done, cnt_wb;

  typedef struct {
    bit cs; bit lv;
    bit step; bit act; bit busy; int elem; bit cl; bit ws; bit wl;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [13:0] dut_outs();
    return {step_en, act_load, wei_load, cl_en_ac1, w_and_s_ac1, MSB_w, MSB_a,
            valid_ac2, valid_ac3, cl_en_ac2, wb, act_wb, busy, done};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_s = 0; m_fil = 0; m_lv = 0; m_v2 = 0; m_v3 = 0;
  endtask

  task automatic clear_counts();
    cnt_step = 0; cnt_v2 = 0; cnt_v3 = 0; cnt_msbw = 0; cnt_msba = 0; cnt_done = 0; cnt_wb = 0;
  endtask

  // One clock: drive inputs, compare at the falling edge, advance the model, return to posedge+1.
  task automatic cyc(input bit cs, input bit dq, input bit rd, input bit lv);
    int s, e, wbt, ab;
    bit stp, nv2, nv3, msba;
    logic [13:0] ev;
    core_stall_n = cs; done_quant = dq; relu_done = rd; last_vol = lv;
    @(negedge clk);
    s   = (m_mode == M_IDLE || m_mode == M_LOAD) ? 0 : ((m_mode == M_RUN) ? m_s : STEPS - 1);
    e   = s % KW;
    wbt = (s / KW) % WB;
    ab  = s / (KW * WB);
    stp = (m_mode == M_RUN) && (cs || (m_lv && m_fil == NF - 1));
`ifdef SMAC_SIGNED_ACT_EN
    msba = stp && (ab == AB - 1);
`else
    msba = 1'b0;
`endif
    ev = {stp, (m_mode == M_LOAD) && cs, stp && ab == 0 && wbt == 0, stp && e == 0, stp && e != 0,
          stp && wbt == WB - 1, msba, m_v2, m_v3, m_v3, m_mode == M_WB, m_mode == M_WB,
          m_mode != M_IDLE, m_mode == M_FIN};
    check("outputs", dut_outs(), ev);
    check("indices", {elem_idx, wbit_idx, abit_idx, fil_idx},
          {EW'(e), WW'(wbt), AW'(ab), FW'(m_fil)});
    sn_step = step_en; sn_act = act_load; sn_busy = busy; sn_elem = elem_idx; sn_cl = cl_en_ac1;
    sn_ws = w_and_s_ac1; sn_wl = wei_load; sn_fil = fil_idx; sn_done = done; sn_wb = wb;
    cnt_step += step_en; cnt_v2 += valid_ac2; cnt_v3 += valid_ac3; cnt_msbw += MSB_w;
    cnt_msba += MSB_a; cnt_done += done; cnt_wb += wb;
    nv2 = stp && e == KW - 1;
    nv3 = nv2 && wbt == WB - 1;
    case (m_mode)
      M_IDLE: if (cs) m_mode = M_LOAD;
      M_LOAD: if (cs) begin m_lv = lv; m_mode = M_RUN; m_s = 0; m_fil = 0; end
      M_RUN:  if (stp) begin if (m_s == STEPS - 1) m_mode = M_QW; else m_s++; end
      M_QW:   if (dq) m_mode = M_WB;
      M_WB:   if (rd) begin
                if (m_fil == NF - 1) m_mode = M_FIN;
                else begin m_fil++; m_s = 0; m_mode = M_RUN; end
              end
      default: begin m_mode = M_IDLE; m_s = 0; m_fil = 0; end
    endcase
    m_v2 = nv2; m_v3 = nv3;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", dut_outs(), 14'h0);
    check("reset_indices", {elem_idx, wbit_idx, abit_idx, fil_idx}, '0);
    rst_n = 1'b1;
    clear_counts();
  endtask

  initial begin
    int cycles, k;
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[3] = '{1, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[4] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
    tbl[5] = '{0, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[6] = '{1, 0, 1, 0, 1, 1, 0, 1, 1};
    tbl[7] = '{1, 0, 1, 0, 1, 2, 0, 1, 1};
    clear_counts();
    do_reset();

    // Start-up vectors
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].cs, 1'b1, 1'b1, tbl[i].lv);
      check($sformatf("vec%0d_flags", i), {sn_step[0], sn_act[0], sn_busy[0], sn_cl[0], sn_ws[0], sn_wl[0]},
            {tbl[i].step, tbl[i].act, tbl[i].busy, tbl[i].cl, tbl[i].ws, tbl[i].wl});
      check($sformatf("vec%0d_elem", i), sn_elem, tbl[i].elem);
    end

    // Full volume, no stalls
    do_reset();
    cycles = 0;
    while (cycles < 5000) begin
      cyc(1, 1, 1, 0);
      cycles++;
      if (sn_done != 0) break;
    end
    check("volume_latency", cycles, 2 + NF * (STEPS + 2) + 1);
    check("volume_steps", cnt_step, NF * STEPS);
    check("volume_valid_ac2", cnt_v2, NF * WB * AB);
    check("volume_valid_ac3", cnt_v3, NF * AB);
    check("volume_msb_w", cnt_msbw, NF * KW * AB);
    check("volume_msb_a", cnt_msba, NF * MSBA_PER_FIL);
    check("volume_done_count", cnt_done, 1);
    cyc(1, 1, 1, 0);
    check("idle_after_done", {sn_busy[0], sn_done[0]}, 2'b00);

    // Stall five cycles at elem 4
    do_reset();
    k = 0;
    while (k < 100 && !(sn_step != 0 && sn_elem == 3)) begin cyc(1, 1, 1, 0); k++; end
    check("stall_reach_elem3", k < 100, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 1, 0);
      check("stall_frozen", {sn_step[0], sn_elem[EW-1:0]}, {1'b0, EW'(4)});
    end
    k = 0;
    while (k < 2 * STEPS && sn_wb == 0) begin cyc(1, 1, 1, 0); k++; end
    check("stall_filter_steps", cnt_step, STEPS);

    // Drain mode on the last filter of the last volume
    do_reset();
    cyc(1, 1, 1, 1);
    cyc(1, 1, 1, 1);
    for (int i = 0; i < 20; i++) cyc(0, 1, 1, 0);
    check("drain_no_early_steps", {cnt_step, sn_fil}, 64'h0);
    k = 0;
    while (k < NF * (STEPS + 4) && !(sn_wb != 0 && sn_fil == NF - 2)) begin cyc(1, 1, 1, 0); k++; end
    check("drain_reach_last_fil", k < NF * (STEPS + 4), 1);
    clear_counts();
    k = 0;
    while (k < STEPS + 10 && sn_done == 0) begin cyc(0, 1, 1, 0); k++; end
    check("drain_done", cnt_done, 1);
    check("drain_steps", cnt_step, STEPS);

    // Delayed relu_done holds write-back
    do_reset();
    k = 0;
    while (k < STEPS + 10 && sn_wb == 0) begin cyc(1, 1, 0, 0); k++; end
    for (int i = 0; i < 9; i++) cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    check("relu_wb_cycles", cnt_wb, 11);
    cyc(1, 1, 1, 0);
    check("relu_next_filter", {sn_wb[0], sn_step[0], sn_fil[FW-1:0], sn_elem[EW-1:0]},
          {1'b0, 1'b1, FW'(1), EW'(0)});

    // Asynchronous reset mid-run, then restart
    do_reset();
    k = 0;
    while (k < 400 && cnt_step < 300) begin cyc(1, 1, 1, 0); k++; end
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", dut_outs(), 14'h0);
    check("async_reset_indices", {elem_idx, wbit_idx, abit_idx, fil_idx}, '0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("async_reset_no_done", cnt_done, 0);
    clear_counts();
    k = 0;
    while (k < STEPS + 10 && sn_wb == 0) begin cyc(1, 1, 1, 0); k++; end
    check("restart_filter_steps", cnt_step, STEPS);

    // Randomized handshakes against the model
    do_reset();
    k = 0;
    while (k < 40000 && cnt_done < 4) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1);
      k++;
    end
    check("random_volumes", cnt_done, 4);
    check("random_steps", cnt_step, 4 * NF * STEPS);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
